// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EXU stage.
// One operation is accepted over valid/ready and runs in 32 single-bit steps.
// Multiply is a shift-add over operand magnitudes. Divide is restoring over magnitudes.
// Result signs are fixed up on the last step. Divide-by-zero and signed overflow
// bypass the iteration and complete one cycle after the handshake.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] data_rs1,
  input  logic [XLEN-1:0] data_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] md_result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  counter;
  logic              accept;

  // operation context captured at the handshake
  logic [2:0]        op_q;
  logic              neg_q;
  logic [2*XLEN-1:0] work;
  logic [XLEN-1:0]   opnd;

  // handshake-time decode
  logic              is_div, sign_a, sign_b, neg_res;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   mag_a, mag_b, special_res;

  // per-step datapath
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, work_nxt, prod_fix;
  logic [XLEN-1:0]   final_res;

  // two's complement negate when n is set, operand width
  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // two's complement negate when n is set, double width
  function automatic logic [2*XLEN-1:0] neg_w(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // decode signedness, magnitudes and bypass cases from the incoming operands
  always_comb begin
    is_div = op[2];
    sign_a = 1'b0;
    sign_b = 1'b0;
    case (op)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        sign_a = data_rs1[XLEN-1];
        sign_b = data_rs2[XLEN-1];
      end
      3'b010: sign_a = data_rs1[XLEN-1];
      default: ;
    endcase
    mag_a   = neg_x(data_rs1, sign_a);
    mag_b   = neg_x(data_rs2, sign_b);
    // remainder takes the dividend sign, everything else the product of signs
    neg_res = (is_div && op[1]) ? sign_a : (sign_a ^ sign_b);
    div_zero = is_div && (data_rs2 == '0);
    div_ovf  = is_div && !op[0] && (data_rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
               (data_rs2 == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = op[1] ? data_rs1 : '1;
    else          special_res = op[1] ? '0 : data_rs1;
  end

  // one multiply or divide step plus the sign-corrected result of the final step
  always_comb begin
    mul_sum   = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, opnd} : '0);
    mul_nxt   = {mul_sum, work[XLEN-1:1]};
    div_shift = work[2*XLEN-1:XLEN-1];
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    div_rem   = div_diff[XLEN+1] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
    div_nxt   = {div_rem, work[XLEN-2:0], ~div_diff[XLEN+1]};
    work_nxt  = op_q[2] ? div_nxt : mul_nxt;
    prod_fix  = neg_w(work_nxt, neg_q);
    if (op_q[2])
      final_res = op_q[1] ? neg_x(work_nxt[2*XLEN-1:XLEN], neg_q)
                          : neg_x(work_nxt[XLEN-1:0], neg_q);
    else
      final_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  // sequencer state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // sequencer next state; flush aborts from any state
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = special ? DONE : CALC;
        CALC:    if (counter == LAST_STEP) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // sequencer outputs
  always_comb begin
    in_ready  = (state == IDLE) && !flush;
    out_valid = (state == DONE);
    accept    = in_valid && in_ready;
  end

  // step counter
  always_ff @(posedge clk) begin
    if (rst || flush || accept) counter <= '0;
    else if (state == CALC)     counter <= counter + 1'b1;
  end

  // result register, only written at completion so partial values never show
  always_ff @(posedge clk) begin
    if (rst)
      md_result <= '0;
    else if (accept && special)
      md_result <= special_res;
    else if (state == CALC && counter == LAST_STEP && !flush)
      md_result <= final_res;
  end

  // operand capture and iteration datapath
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= op;
      neg_q <= neg_res;
      work  <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
      opnd  <= is_div ? mag_b : mag_a;
    end else if (state == CALC) begin
      work  <= work_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed literal cases plus a randomized run, all
// compared cycle by cycle against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  op;
  logic [31:0] data_rs1, data_rs2, md_result;

  int total = 0;
  int bad   = 0;

  // reference model state: -1 unknown, 0 idle, 1 computing, 2 result held
  int          mstate = -1;
  int          mcnt   = 0;
  logic [31:0] mres   = '0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .data_rs1(data_rs1), .data_rs2(data_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .md_result(md_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ua = longint'({32'd0, a});
    longint      ub = longint'({32'd0, b});
    logic [63:0] p;
    case (o)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 0) return 1'b1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  // reference model: advances on every rising edge from the inputs seen there
  always @(posedge clk) begin
    if (rst) begin
      mstate = 0;
      mres   = '0;
    end else if (mstate >= 0) begin
      if (flush) mstate = 0;
      else case (mstate)
        0: if (in_valid) begin
          mres = ref_md(op, data_rs1, data_rs2);
          if (is_fast(op, data_rs1, data_rs2)) mstate = 2;
          else begin mstate = 1; mcnt = 32; end
        end
        1: begin mcnt--; if (mcnt == 0) mstate = 2; end
        default: if (out_ready) mstate = 0;
      endcase
    end
  end

  // compare DUT outputs with the model mid-cycle
  always @(negedge clk) begin
    if (mstate >= 0) begin
      check("out_valid", out_valid, (mstate == 2));
      check("in_ready", in_ready, (mstate == 0 && !flush));
      if (mstate == 2) check("md_result", md_result, mres);
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // issue one op from an idle unit and check its result and latency against literals
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int explat, input string name);
    bit          got = 0;
    int          lat = 0;
    logic [31:0] res = '0;
    in_valid = 1'b1; op = o; data_rs1 = a; data_rs2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); data_rs1 = $urandom; data_rs2 = $urandom;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; lat = i; res = md_result; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no out_valid expected one within 60 cycles", name);
    end else begin
      check(name, res, exp);
      check({name, "_lat"}, lat, explat);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'd0; data_rs1 = '0; data_rs2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_in_ready", in_ready, 32'd1);
    check("rst_md_result", md_result, 32'd0);
    @(posedge clk); #1;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7xm3");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_min");
    do_op(3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulhu_min");
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu_m1");
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
    do_op(3'd5, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
    do_op(3'd7, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
    do_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
    do_op(3'd6, 32'd5, 32'd0, 32'd5, 1, "rem_by0");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "rem_ovf");

    // result held under backpressure, then released
    out_ready = 1'b0;
    do_op(3'd5, 32'd100, 32'd7, 32'd14, 33, "bp_divu");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid_held", out_valid, 32'd1);
      check("bp_result_held", md_result, 32'd14);
      check("bp_in_ready", in_ready, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_release_ready", in_ready, 32'd1);
    @(posedge clk); #1;
    do_op(3'd7, 32'd100, 32'd7, 32'd2, 33, "bp_next_op");

    // flush in the middle of a multiply
    in_valid = 1'b1; op = 3'd0; data_rs1 = $urandom; data_rs2 = $urandom;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("flush_no_valid", out_valid, 32'd0);
    end
    @(posedge clk); #1;

    // reset in the middle of a divide
    in_valid = 1'b1; op = 3'd4; data_rs1 = $urandom; data_rs2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("rst_no_valid", out_valid, 32'd0);
    end
    @(posedge clk); #1;
    do_op(3'd0, 32'd3, 32'd4, 32'd12, 33, "mul_3x4");

    // randomized traffic with stalls, flushes and occasional resets
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      op        = 3'($urandom);
      data_rs1  = pick();
      data_rs2  = pick();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 199) == 0);
      rst       = ($urandom_range(0, 999) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
